serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised bit-serial subtractor computing a − b − bin on WIDTH-bit operands with a single full-subtractor cell, one bit per clock, LSB first.
- Successor to the single-bit full subtractor: generalised width, borrow chained through a register, valid/ready handshakes on input and output.
- Sits in area-constrained datapaths where an occasional multi-bit subtract can take WIDTH cycles.

Parameters:
- WIDTH, 8: operand and difference width in bits; legal range ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands a, b, bin valid.
- in_ready  output  1  block idle, can accept.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a − b − bin modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when a < b + bin as unsigned values.
- ovf  output  1  signed overflow; present only with SERSUB_OVF_EN.

Behaviour:
- Interface: one clock and synchronous active-low reset, with ports named clk and rst_n, as stated under Ports.
- Reset (rst_n=0 at a clk edge): state IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, counter=0.
- Reset mid-RUN or mid-DONE aborts the operation; no result is produced.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b into shift registers, load the borrow register with bin, clear the counter, go to RUN.
- State RUN:
  - in_ready=0.
  - Each edge: compute the cell on the current LSBs of a and b and the borrow register.
  - The difference bit shifts into diff from the MSB; the new borrow is registered; the a and b shift registers shift right; the counter increments.
  - On the edge where counter==WIDTH-1: go to DONE and set out_valid=1.
  - Input changes during RUN are ignored.
- State DONE:
  - out_valid=1; diff and bout are stable and held.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - in_ready returns to 1 in the cycle after the handshake; no accept happens in the same cycle as a DONE exit.
- Latency: out_valid rises WIDTH cycles after the accepting edge. Minimum issue interval is WIDTH+2 cycles with out_ready held high.
- Counter width: $clog2(WIDTH), minimum 1.
- WIDTH=1: RUN lasts exactly one cycle.
- in_valid while busy: held off because in_ready=0; the source must hold its data until in_ready=1.
- out_ready asserted before out_valid has no effect.
- diff is not guaranteed meaningful while out_valid=0; bout likewise.

Optional Feature:
- Macro: SERSUB_OVF_EN.
- When defined:
  - Add output ovf = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]), two's-complement overflow ignoring bin.
  - Registered with diff; valid with out_valid; reset 0.
  - Requires the operand MSBs to be captured at accept time.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sersub_pkg holds:
  - state enum: IDLE, RUN, DONE;
  - the localparam helper for counter width.
- Natural sub-module: fs_cell, a combinational 1-bit full subtractor.
  - Inputs x, y, bi.
  - Outputs d = x^y^bi and bo = (~x&y) | (~(x^y)&bi).
  - Instantiated once.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, out_ready=1:
  - out_valid rises 8 cycles after accept;
  - diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1.
- a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Second in_valid driven during RUN → in_ready=0, operands not taken, first result unchanged.
- Backpressure: out_ready=0 for 5 cycles after out_valid:
  - diff and out_valid held;
  - out_ready=1 → out_valid=0 next edge, in_ready=1.
- rst_n=0 at RUN cycle 4 → next cycle IDLE, out_valid=0, diff=0; a fresh op then completes correctly.
- With SERSUB_OVF_EN, a=0x80, b=0x01 → diff=0x7F, ovf=1, bout=0.
- With SERSUB_OVF_EN, a=0x7F, b=0x01 → ovf=0.
- WIDTH=1 build: a=0, b=1, bin=0 → diff=1, bout=1 after 1 RUN cycle.

Source files
------------

// File: rtl/sersub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and
// the counter-width helper.
package sersub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit counter width: $clog2(width), never below one bit so WIDTH=1 still
   // has a legal counter.
   function automatic int cnt_width(input int width);
      if (width <= 1) begin
         return 1;
      end
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo set on underflow.
module fs_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, one bit per
// clock, LSB first, through a single full-subtractor cell.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; in_ready is 1 only in IDLE, out_valid is 1 only in DONE, and
// diff/bout (and ovf) are held stable for as long as out_valid is 1.
// Optional feature: define SERSUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
   import sersub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;
   logic [WIDTH-1:0] diff_nxt;
   logic             borrow_q;
   logic [CW-1:0]    cnt_q;
   logic             cell_d;
   logic             cell_bo;
   logic             last_bit;

   // The single cell always works on the current operand LSBs.
   fs_cell u_cell (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .bi (borrow_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   // New difference bits enter at the MSB so the LSB ends up at bit 0.
   generate
      if (WIDTH == 1) begin : g_w1
         assign diff_nxt = cell_d;
      end else begin : g_wn
         assign diff_nxt = {cell_d, diff_q[WIDTH-1:1]};
      end
   endgenerate

   assign last_bit = (cnt_q == LAST);

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand shift registers, borrow chain, difference and bit counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= bin;
                  cnt_q    <= '0;
               end
            end
            RUN: begin
               diff_q   <= diff_nxt;
               borrow_q <= cell_bo;
               a_q      <= a_q >> 1;
               b_q      <= b_q >> 1;
               cnt_q    <= cnt_q + ONE;
            end
            default: begin
            end
         endcase
      end
   end

   assign diff = diff_q;
   assign bout = borrow_q;

`ifdef SERSUB_OVF_EN
   logic a_msb_q;
   logic b_msb_q;
   logic ovf_q;

   // Operand MSBs are shifted away during RUN, so keep them from accept time;
   // overflow is resolved on the edge that produces the final diff MSB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state_q == IDLE && in_valid) begin
         a_msb_q <= a[WIDTH-1];
         b_msb_q <= b[WIDTH-1];
      end else if (state_q == RUN && last_bit) begin
         ovf_q <= (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed test of serial_subtractor (WIDTH=8 main instance, WIDTH=1 side
// instance). Expected results are queued at accept and checked by a monitor
// when the DUT hands a result over.
module tb_serial_subtractor;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- WIDTH=8 DUT ----------------
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   serial_subtractor #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef SERSUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // ---------------- WIDTH=1 DUT ----------------
   logic w1_in_valid;
   logic w1_in_ready;
   logic w1_a;
   logic w1_b;
   logic w1_bin;
   logic w1_out_valid;
   logic w1_out_ready;
   logic w1_diff;
   logic w1_bout;
   logic w1_ovf;

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w1_in_valid),
      .in_ready  (w1_in_ready),
      .a         (w1_a),
      .b         (w1_b),
      .bin       (w1_bin),
      .out_valid (w1_out_valid),
      .out_ready (w1_out_ready),
      .diff      (w1_diff),
      .bout      (w1_bout)
`ifdef SERSUB_OVF_EN
      ,
      .ovf       (w1_ovf)
`endif
   );

`ifndef SERSUB_OVF_EN
   assign ovf    = 1'b0;
   assign w1_ovf = 1'b0;
`endif

   // ---------------- scoreboard ----------------
   logic [W+1:0] exp_q[$];   // {ovf, bout, diff}
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every result handed over on the main DUT.
   logic [W+1:0] mon_e;
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("diff", 32'(diff), 32'(mon_e[W-1:0]));
            check("bout", 32'(bout), 32'(mon_e[W]));
`ifdef SERSUB_OVF_EN
            check("ovf", 32'(ovf), 32'(mon_e[W+1]));
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input bit expect_result);
      int guard;
      guard = 0;
      @(posedge clk); #1;
      a        = ta;
      b        = tb;
      bin      = tbin;
      in_valid = 1'b1;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) check("issue_timeout", 32'd0, 32'd1);
      if (expect_result) exp_q.push_back({eo, eb, ed});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (exp_q.size() != 0 || out_valid) check("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic w1_run(input logic ta, input logic tb, input logic tbin,
                         input logic ed, input logic eb, input logic eo);
      @(posedge clk); #1;
      check("w1_in_ready", 32'(w1_in_ready), 32'd1);
      w1_a        = ta;
      w1_b        = tb;
      w1_bin      = tbin;
      w1_in_valid = 1'b1;
      @(posedge clk); #1;           // accept edge
      w1_in_valid = 1'b0;
      check("w1_run_not_valid", 32'(w1_out_valid), 32'd0);
      @(posedge clk); #1;           // single RUN edge
      check("w1_out_valid", 32'(w1_out_valid), 32'd1);
      check("w1_diff", 32'(w1_diff), 32'(ed));
      check("w1_bout", 32'(w1_bout), 32'(eb));
`ifdef SERSUB_OVF_EN
      check("w1_ovf", 32'(w1_ovf), 32'(eo));
`endif
      @(posedge clk); #1;           // handshake edge, out_ready held high
      check("w1_release", 32'(w1_out_valid), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      a            = '0;
      b            = '0;
      bin          = 1'b0;
      w1_in_valid  = 1'b0;
      w1_out_ready = 1'b1;
      w1_a         = 1'b0;
      w1_b         = 1'b0;
      w1_bin       = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
`ifdef SERSUB_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      check("rst_w1_out_valid", 32'(w1_out_valid), 32'd0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // Latency: out_valid rises exactly WIDTH edges after the accept edge.
      issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
      repeat (7) @(posedge clk);
      @(negedge clk);
      check("latency_early", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("latency_rise", 32'(out_valid), 32'd1);
      wait_drain();

      // Borrow cases.
      issue(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1);
      issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
      wait_drain();

      // Busy: a second request during RUN must be held off.
      issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      a        = 8'h11;
      b        = 8'h22;
      bin      = 1'b1;
      in_valid = 1'b1;
      repeat (3) begin
         check("busy_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_drain();

      // Backpressure: result held while out_ready is low.
      out_ready = 1'b0;
      issue(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
      guard = 0;
      while (!out_valid && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!out_valid) check("bp_wait_timeout", 32'd0, 32'd1);
      repeat (5) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_diff_hold", 32'(diff), 32'h7E);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      wait_drain();

      // Reset during RUN cycle 4 aborts the operation.
      issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_bout", 32'(bout), 32'd0);
      rst_n = 1'b1;

      // Fresh operations after the abort.
      issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
      issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
      issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1);
      wait_drain();

      // WIDTH=1 instance.
      w1_run(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      w1_run(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      w1_run(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
